tile_stream_fifo: RTL

Parametrised successor tile FIFO that buffers rectangular ROWS x COLS tiles of BITS-bit elements between systolic-array stages. It adds the following over the previous tile FIFO:
- true DEPTH-entry storage, with no wasted slot and support for non-power-of-two depths
- selectable standard or first-word-fall-through (FWFT) read mode
- synchronous flush
- almost-full and almost-empty thresholds
- sticky overflow and underflow error flags

It sits between the tile loader and the array feeder, and between the array drain and writeback.

---
 rtl/tile_stream_fifo_if.sv | 36 +++
 rtl/tile_stream_fifo.sv | 111 +++++++++++
 2 files changed

// File: rtl/tile_stream_fifo_if.sv
// Handshake and status bundle for tile_stream_fifo.
// The master side writes tiles and issues pops. The slave side is the FIFO.
interface tile_stream_fifo_if #(
    parameter int BITS  = 8,
    parameter int ROWS  = 2,
    parameter int COLS  = 2,
    parameter int DEPTH = 3
);
    localparam int CW = $clog2(DEPTH + 1);

    logic                                  flush;
    logic                                  push;
    logic                                  push_rdy;
    logic [ROWS-1:0][COLS-1:0][BITS-1:0]   din;
    logic                                  pop;
    logic                                  pop_rdy;
    logic [ROWS-1:0][COLS-1:0][BITS-1:0]   dout;
    logic                                  dout_vld;
    logic [CW-1:0]                         count;
    logic                                  almost_full;
    logic                                  almost_empty;
    logic                                  ovf;
    logic                                  udf;

    modport master (
        output flush, push, din, pop,
        input  push_rdy, pop_rdy, dout, dout_vld, count,
               almost_full, almost_empty, ovf, udf
    );

    modport slave (
        input  flush, push, din, pop,
        output push_rdy, pop_rdy, dout, dout_vld, count,
               almost_full, almost_empty, ovf, udf
    );
endinterface

// File: rtl/tile_stream_fifo.sv
// Tile FIFO with a DEPTH-entry circular buffer and an explicit occupancy count.
// Read mode is selectable: a registered read on pop, or first-word-fall-through.
// Pointers wrap at DEPTH-1, so non-power-of-two depths use every slot.
module tile_stream_fifo #(
    parameter int BITS      = 8,
    parameter int ROWS      = 2,
    parameter int COLS      = 2,
    parameter int DEPTH     = 3,
    parameter int FWFT      = 0,
    parameter int AFULL_TH  = DEPTH - 1,
    parameter int AEMPTY_TH = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    tile_stream_fifo_if.slave   bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    typedef logic [ROWS-1:0][COLS-1:0][BITS-1:0] tile_t;

    tile_t          mem [DEPTH];
    logic [PW-1:0]  head;
    logic [PW-1:0]  tail;
    logic [CW-1:0]  cnt;
    logic           ovf_r;
    logic           udf_r;
    logic           full;
    logic           empty;
    logic           push_acc;
    logic           pop_acc;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full     = (cnt == CW'(DEPTH));
    assign empty    = (cnt == '0);
    // Flush wins over both requests. When the FIFO is full, a push is refused
    // even if a pop in the same cycle frees a slot.
    assign push_acc = bus.push & ~full  & ~bus.flush;
    assign pop_acc  = bus.pop  & ~empty & ~bus.flush;

    assign bus.push_rdy     = ~full;
    assign bus.pop_rdy      = ~empty;
    assign bus.count        = cnt;
    assign bus.almost_full  = (int'(cnt) >= AFULL_TH);
    assign bus.almost_empty = (int'(cnt) <= AEMPTY_TH);
    assign bus.ovf          = ovf_r;
    assign bus.udf          = udf_r;

    // Storage write; the array is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (push_acc) begin
            mem[tail] <= bus.din;
        end
    end

    // Pointers, occupancy and sticky error flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head  <= '0;
            tail  <= '0;
            cnt   <= '0;
            ovf_r <= 1'b0;
            udf_r <= 1'b0;
        end else if (bus.flush) begin
            head  <= '0;
            tail  <= '0;
            cnt   <= '0;
            ovf_r <= 1'b0;
            udf_r <= 1'b0;
        end else begin
            if (push_acc) tail <= next_ptr(tail);
            if (pop_acc)  head <= next_ptr(head);
            case ({push_acc, pop_acc})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
            if (bus.push && full)  ovf_r <= 1'b1;
            if (bus.pop  && empty) udf_r <= 1'b1;
        end
    end

    generate
        if (FWFT == 0) begin : g_std
            tile_t dout_r;
            logic  vld_r;

            // Registered read: the head tile is captured on an accepted pop.
            // The valid pulse lasts exactly one cycle.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    dout_r <= '0;
                    vld_r  <= 1'b0;
                end else begin
                    vld_r <= pop_acc;
                    if (pop_acc) dout_r <= mem[head];
                end
            end

            assign bus.dout     = dout_r;
            assign bus.dout_vld = vld_r;
        end else begin : g_fwft
            // Head tile is always presented. It is valid whenever the FIFO holds data.
            assign bus.dout     = mem[head];
            assign bus.dout_vld = ~empty;
        end
    endgenerate
endmodule
